// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and per-boundary width defaults for the pipeline
// stage registers (pipe_stage, pipe_sat_counter).
package pipe_pkg;

   // Occupancy of a stage: EMPTY, main entry only, main plus skid entry.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } pipe_state_e;

   // Default control/payload widths for each inter-stage boundary.
   localparam int IF_ID_CTRL_W  = 4;
   localparam int IF_ID_DATA_W  = 64;
   localparam int ID_EX_CTRL_W  = 8;
   localparam int ID_EX_DATA_W  = 128;
   localparam int EX_MEM_CTRL_W = 6;
   localparam int EX_MEM_DATA_W = 104;
   localparam int MEM_WB_CTRL_W = 3;
   localparam int MEM_WB_DATA_W = 72;

   // Default width of the stall performance counter.
   localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating up-counter with asynchronous active-high
// reset. Sticks at all-ones instead of wrapping; reusable for perf counters.
module pipe_sat_counter
   import pipe_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: increment on request unless already saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Count register; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline-stage register carrying a control field
// and a payload. Control is zeroed on every bubble so a killed instruction
// can never write architectural state; flush drops the held beat and the
// beat offered in the same cycle.
// Handshake: a beat moves upstream->stage when in_valid && in_ready, and
// stage->downstream when out_valid && out_ready; out_valid never drops
// while a beat is stalled.
// Build option PIPE_SKID_EN: adds one skid entry and registers in_ready so
// there is no combinational path out_ready->in_ready. Without it the stage
// holds a single entry and in_ready is combinational from out_ready.
// dbg_state reports occupancy (EMPTY/ONE/FULL encoding from pipe_pkg).
module pipe_stage
   import pipe_pkg::*;
#(
   parameter int CTRL_W = ID_EX_CTRL_W,
   parameter int DATA_W = ID_EX_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [1:0]        dbg_state
);

   logic              valid_q, valid_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              accept, emit, stall_inc;

   assign accept    = in_valid && in_ready;
   assign emit      = valid_q && out_ready;
   assign stall_inc = valid_q && !out_ready && !flush;

`ifdef PIPE_SKID_EN
   pipe_state_e       state_q, state_d;
   logic [CTRL_W-1:0] sk_ctrl_q, sk_ctrl_d;
   logic [DATA_W-1:0] sk_data_q, sk_data_d;
   logic              in_ready_q, in_ready_d;

   // Occupancy FSM: routes accepted beats to main or skid and keeps order.
   always_comb begin
      state_d   = state_q;
      ctrl_d    = ctrl_q;
      data_d    = data_q;
      sk_ctrl_d = sk_ctrl_q;
      sk_data_d = sk_data_q;
      if (flush) begin
         state_d   = EMPTY;
         ctrl_d    = '0;
         sk_ctrl_d = '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  ctrl_d  = in_ctrl;
                  data_d  = in_data;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (accept && emit) begin
                  ctrl_d = in_ctrl;
                  data_d = in_data;
               end else if (accept) begin
                  sk_ctrl_d = in_ctrl;
                  sk_data_d = in_data;
                  state_d   = FULL;
               end else if (emit) begin
                  ctrl_d  = '0;
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (emit) begin
                  ctrl_d    = sk_ctrl_q;
                  data_d    = sk_data_q;
                  sk_ctrl_d = '0;
                  state_d   = ONE;
               end
            end
            default: begin
               state_d   = EMPTY;
               ctrl_d    = '0;
               sk_ctrl_d = '0;
            end
         endcase
      end
      valid_d    = (state_d != EMPTY);
      in_ready_d = (state_d != FULL);
   end

   // Skid storage, FSM state and the registered ready flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         sk_ctrl_q  <= '0;
         sk_data_q  <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         sk_ctrl_q  <= sk_ctrl_d;
         sk_data_q  <= sk_data_d;
         in_ready_q <= in_ready_d;
      end
   end

   // Flush opens the input so the killed beat is consumed and dropped.
   assign in_ready  = in_ready_q || flush;
   assign dbg_state = state_q;
`else
   // Single entry: load on accept, bubble on emit-only, kill on flush.
   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      if (flush) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end else if (accept) begin
         valid_d = 1'b1;
         ctrl_d  = in_ctrl;
         data_d  = in_data;
      end else if (emit) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end
   end

   assign in_ready  = flush || !valid_q || out_ready;
   assign dbg_state = valid_q ? ONE : EMPTY;
`endif

   // Main entry registers seen by the downstream stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_ctrl  = ctrl_q;
   assign out_data  = data_q;

   pipe_sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (stall_inc),
      .cnt_o (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: randomized and directed stimulus for pipe_stage, checked by
// a queue-based model of the stage (capacity 1, or 2 with PIPE_SKID_EN).
// A second instance with a 4-bit stall counter shares all inputs.
module tb_pipe_stage;

  localparam int CTRL_W = 8;
  localparam int DATA_W = 128;
  localparam int W      = CTRL_W + DATA_W;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  // clock/reset and stimulus signals
  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_ready;

  logic              in_ready, out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [15:0]       stall_cnt;
  logic [1:0]        dbg_state;

  logic              in_ready4, out_valid4;
  logic [CTRL_W-1:0] out_ctrl4;
  logic [DATA_W-1:0] out_data4;
  logic [3:0]        stall_cnt4;
  logic [1:0]        dbg_state4;

  pipe_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  pipe_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
    .out_ctrl(out_ctrl4), .out_data(out_data4), .stall_cnt(stall_cnt4), .dbg_state(dbg_state4)
  );

  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  stall_exp = 0;
  int  stall4_exp = 0;
  bit  mon_en = 1'b0;
  int  mon_n;
  bit  mon_ev, mon_er, mon_acc, mon_emt;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: change inputs just after the rising edge
  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic r, input logic f);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = {$urandom, $urandom, $urandom, $urandom};
    out_ready = r;
    flush     = f;
  endtask

  // monitor: compare DUT against the model mid-cycle, then advance the model
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      mon_n  = exp_q.size();
      mon_ev = (mon_n != 0);
      mon_er = SKID ? (flush || mon_n < 2) : (flush || mon_n == 0 || out_ready);
      chk("out_valid", W'(out_valid), W'(mon_ev));
      chk("in_ready", W'(in_ready), W'(mon_er));
      chk("stall_cnt", W'(stall_cnt), W'(stall_exp));
      chk("stall_cnt4", W'(stall_cnt4), W'(stall4_exp));
      chk("dbg_state", W'(dbg_state), W'(mon_n));
      if (mon_ev) begin
        chk("out_ctrl", W'(out_ctrl), W'(exp_q[0][W-1:DATA_W]));
        chk("out_data", W'(out_data), W'(exp_q[0][DATA_W-1:0]));
      end else begin
        chk("out_ctrl_bubble", W'(out_ctrl), W'(0));
      end
      mon_acc = in_valid && mon_er;
      mon_emt = mon_ev && out_ready;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (mon_ev && !out_ready) begin
          if (stall_exp < 65535) stall_exp++;
          if (stall4_exp < 15) stall4_exp++;
        end
        if (mon_emt) void'(exp_q.pop_front());
        if (mon_acc) exp_q.push_back({in_ctrl, in_data});
      end
    end
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'hFF;
    in_data   = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b0;

    // reset with a beat offered: everything cleared, input open
    repeat (2) @(negedge clk);
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_ctrl", W'(out_ctrl), W'(0));
    chk("rst_out_data", W'(out_data), W'(0));
    chk("rst_stall_cnt", W'(stall_cnt), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_dbg_state", W'(dbg_state), W'(0));

    // release reset with the 8'hFF beat still offered
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    mon_en    = 1'b1;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk("first_out_valid", W'(out_valid), W'(1));
    chk("first_out_ctrl", W'(out_ctrl), W'(8'hFF));

    // stream of 10 beats at full rate
    for (int i = 0; i < 10; i++) drive(1'b1, 8'($urandom), 1'b1, 1'b0);
    repeat (2) drive(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk("stream_stall_cnt", W'(stall_cnt), W'(0));

    // 5-cycle back-pressure with a further beat offered throughout
    drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    repeat (5) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk("stall5_cnt", W'(stall_cnt), W'(5));
    repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0);

    // 20-cycle stall: 4-bit counter must stick at 15
    drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    repeat (20) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk("stall25_cnt", W'(stall_cnt), W'(25));
    chk("sat_cnt4", W'(stall_cnt4), W'(15));
    repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0);

    // fill the stage (FULL with skid), then flush with a beat offered
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    drive(1'b1, 8'hC3, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_out_valid", W'(out_valid), W'(0));
    chk("flush_out_ctrl", W'(out_ctrl), W'(0));
    chk("flush_in_ready", W'(in_ready), W'(1));
    chk("flush_stall_cnt", W'(stall_cnt), W'(26));
    repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0);

    // random traffic with occasional flushes
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 19) == 0));
    repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0);

    // asynchronous reset in the middle of a stall
    drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", W'(out_valid), W'(0));
    chk("arst_out_ctrl", W'(out_ctrl), W'(0));
    chk("arst_out_data", W'(out_data), W'(0));
    chk("arst_stall_cnt", W'(stall_cnt), W'(0));
    chk("arst_stall_cnt4", W'(stall_cnt4), W'(0));
    exp_q.delete();
    stall_exp  = 0;
    stall4_exp = 0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;

    // traffic after reset recovers normally
    for (int i = 0; i < 10; i++) drive(1'b1, 8'($urandom), 1'b1, 1'b0);
    repeat (2) drive(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk("post_rst_stall_cnt", W'(stall_cnt), W'(0));
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised pipeline-stage register for the RISC-V core, replacing the fixed-field, always-load inter-stage registers. It carries an arbitrary control field plus data payload between stages with a valid/ready handshake, supports back-pressure (stall) and flush (bubble insertion), and zeroes control bits on any bubble so a killed instruction can never write state. It sits between IF/ID, ID/EX, EX/MEM and MEM/WB; one instance per boundary.

## Interface
- CTRL_W, 8: control-field width (RegWrite, MemRead, MemWrite, ALUop, …); cleared on bubbles.
- DATA_W, 128: payload width (operands, immediate, PC, register indices); never cleared except at reset.
- CNT_W, 16: stall-counter width.

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  kill contents and the incoming beat this cycle
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat
- in_ctrl  in  CTRL_W  upstream control field
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  stage holds a valid beat
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  registered control, zero whenever out_valid=0
- out_data  out  DATA_W  registered payload
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- Accept when in_valid && in_ready; emit when out_valid && out_ready.
- Base mode (single entry): in_ready = !out_valid || out_ready (combinational). On accept, out_ctrl/out_data load in_ctrl/in_data, out_valid ← 1. On emit without accept, out_valid ← 0, out_ctrl ← 0, out_data holds.
- Stall: out_valid && !out_ready → all outputs hold, in_ready=0, stall_cnt += 1 saturating at 2^CNT_W−1 (no wrap).
- Flush: priority over everything. Next edge: out_valid ← 0, out_ctrl ← 0, skid emptied; in_ready forced 1 during flush; the beat presented that cycle is dropped; out_data holds. stall_cnt not incremented in a flush cycle.
- out_ctrl is exactly zero whenever out_valid=0 (invariant).
- stall_cnt cleared by reset only.
- Reset: out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, skid empty, state EMPTY; in_ready=1 in base mode, 1 in skid mode. Reset asserted mid-transfer discards all content immediately (asynchronous).

## Timing
- Latency: 1 cycle in_valid→out_valid. Throughput: 1 beat/cycle with out_ready held high.
- Base mode: combinational path out_ready→in_ready.
- Skid mode: in_ready is a register output; no combinational path between ready signals.
- Simultaneous accept+emit in base mode: new beat replaces old, out_valid stays 1.

## Configuration
- PIPE_SKID_EN defined: adds one skid entry (ctrl+data+valid). State machine EMPTY → (accept) ONE; ONE → (accept, no emit) FULL; ONE → (emit, no accept) EMPTY; ONE with accept+emit stays ONE; FULL → (emit) ONE, skid moves to main. in_ready = (state≠FULL), registered. Beat accepted while downstream stalls goes into skid; order preserved. Flush from any state → EMPTY.
- Undefined: single-entry base mode; no skid storage, no state register beyond out_valid.

## Structure
- Package pipe_pkg: state enum (EMPTY, ONE, FULL), default width constants per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB CTRL_W/DATA_W).
- Sub-module pipe_sat_counter (CNT_W, inc, async rst) for stall_cnt; reusable for other perf counters.

## Test plan
- Reset with in_valid=1, in_ctrl=8'hFF: all outputs zero, in_ready=1; release, one accept → next cycle out_valid=1, out_ctrl=8'hFF.
- Stream 10 beats with out_ready=1: 10 beats out in order, one per cycle, 1-cycle latency, stall_cnt=0.
- Hold out_ready=0 for 5 cycles with a valid beat: outputs stable, stall_cnt=5; base mode in_ready=0; skid mode accepts exactly one more beat then in_ready=0, both beats delivered in order after release.
- Flush while FULL (skid) with in_valid=1: next cycle out_valid=0, out_ctrl=0, in_ready=1, flushed-cycle beat never appears.
- CNT_W=4, 20-cycle stall: stall_cnt saturates at 15, no wrap.
- Assert rst asynchronously mid-stall: outputs zero before next clk edge, stall_cnt=0.
